// File: rtl/data_mem_responder.sv
// Word-organised data memory behind valid/ready request and response channels.
// Each access waits WAIT_CYCLES states, then answers with load data or a store acknowledgement.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit_s;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the commit happens on the accepting edge, so it must
  // use the values being latched on that same edge.
  logic              from_live_s;
  logic              txn_write_s;
  logic [31:0]       txn_addr_s;
  logic [31:0]       txn_wdata_s;
  logic [3:0]        txn_be_s;
  logic [32:0]       off_s;
  logic              ok_s;
  logic [IDX_W-1:0]  word_idx_s;
  logic [31:0]       mem_rd_s;

  assign from_live_s = (state_q == S_IDLE);
  assign txn_write_s = from_live_s ? req_write : write_q;
  assign txn_addr_s  = from_live_s ? req_addr  : addr_q;
  assign txn_wdata_s = from_live_s ? req_wdata : wdata_q;
  assign txn_be_s    = from_live_s ? req_be    : be_q;

  // Borrow out of the 33-bit subtraction means the address lies below BASE_ADDR.
  assign off_s      = {1'b0, txn_addr_s} - {1'b0, BASE_ADDR};
  assign ok_s       = (txn_addr_s[1:0] == 2'b00) && !off_s[32] && (off_s < SPAN_BYTES);
  assign word_idx_s = off_s[IDX_W+1:2];
  assign mem_rd_s   = mem_q[word_idx_s];

  // Next-state, request latching and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d  = S_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (commit_s) begin
      err_d   = !ok_s;
      rdata_d = (ok_s && !txn_write_s) ? mem_rd_s : 32'd0;
    end else begin
      err_d = err_d;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; a store lands only on its commit edge.
  always_ff @(posedge clk) begin
    if (commit_s && rst && ok_s && txn_write_s) begin
      for (int i = 0; i < 4; i++) begin
        if (txn_be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= txn_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder, covering a 2-wait-state instance
// and a 0-wait-state instance, exercised one after the other.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be    = 4'd0;
  logic        rsp_ready = 1'b0;
  logic        sel = 1'b0;
  int          bp_mode = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        vin_a, rdy_a, vld_a, err_a;
  logic        vin_b, rdy_b, vld_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        cur_rdy, cur_vld, cur_err;
  logic [31:0] cur_rdata;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [2][DEPTH];

  assign vin_a     = req_valid & ~sel;
  assign vin_b     = req_valid & sel;
  assign cur_rdy   = sel ? rdy_b   : rdy_a;
  assign cur_vld   = sel ? vld_b   : vld_a;
  assign cur_err   = sel ? err_b   : err_a;
  assign cur_rdata = sel ? rdata_b : rdata_a;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(vin_a), .req_ready(rdy_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld_a),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vin_b), .req_ready(rdy_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld_b),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // Response-channel ready: random, forced low, or forced high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1) rsp_ready = 1'b0;
      else if (bp_mode == 2) rsp_ready = 1'b1;
      else rsp_ready = ($urandom_range(3) != 0);
    end
  end

  // Monitor: latency, stability under backpressure, payload and post-handshake idle.
  initial begin
    logic        prev_valid;
    logic        idle_chk;
    logic [31:0] hold_d;
    logic        hold_e;
    prev_valid = 1'b0;
    idle_chk   = 1'b0;
    hold_d     = 32'd0;
    hold_e     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        idle_chk   = 1'b0;
      end else begin
        if (idle_chk) begin
          check("valid_drops_after_hs", 32'(cur_vld), 32'd0);
          check("ready_back_after_hs", 32'(cur_rdy), 32'd1);
          idle_chk = 1'b0;
        end
        if (cur_vld) begin
          check("req_ready_low_in_resp", 32'(cur_rdy), 32'd0);
          if (!prev_valid) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request, expected 0");
            end else begin
              check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(sb_q[0].lat));
            end
            hold_d = cur_rdata;
            hold_e = cur_err;
          end else begin
            check("rdata_stable", cur_rdata, hold_d);
            check("err_stable", 32'(cur_err), 32'(hold_e));
          end
          if (rsp_ready && sb_q.size() > 0) begin
            check("rsp_rdata", cur_rdata, sb_q[0].rdata);
            check("rsp_err", 32'(cur_err), 32'(sb_q[0].err));
            void'(sb_q.pop_front());
            idle_chk = 1'b1;
          end
        end
        prev_valid = cur_vld;
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t        e;
    bit          ok;
    bit          got;
    int unsigned idx;
    int          s;
    s = int'(sel);
    @(posedge clk);
    #1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cur_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for 300 cycles, expected 1");
    end else begin
      ok  = (a[1:0] == 2'b00) && (a >= BASE) &&
            ((longint'(a) - longint'(BASE)) < longint'(4 * DEPTH));
      idx = ok ? ((a - BASE) >> 2) : 0;
      if (ok && w) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) ref_mem[s][idx][8*i +: 8] = d[8*i +: 8];
        end
      end
      e.rdata   = (ok && !w) ? ref_mem[s][idx] : 32'd0;
      e.err     = !ok;
      e.acc_cyc = cyc;
      e.lat     = sel ? 1 : 3;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && cur_rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d responses outstanding after 500 cycles, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic init_words();
    for (int i = 0; i < 20; i++) begin
      int unsigned idx;
      idx = (i < 16) ? i : (DEPTH - 20 + i);
      issue(1'b1, BASE + 32'(4 * idx), $urandom, 4'hF);
    end
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      int unsigned w, idx, kind;
      logic [31:0] a;
      logic [3:0]  be;
      w    = $urandom_range(19);
      idx  = (w < 16) ? w : (DEPTH - 20 + w);
      a    = BASE + 32'(4 * idx);
      kind = $urandom_range(11);
      if (kind == 0) a = a + 32'($urandom_range(3, 1));
      else if (kind == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(3));
      else if (kind == 2) a = BASE - 32'(4 * $urandom_range(4, 1));
      else if (kind == 3) a = 32'h0040_0000;
      be = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom);
      issue(1'($urandom), a, $urandom, be);
    end
  endtask

  initial begin
    bit got;
    #3;
    check("rst_req_ready_a", 32'(rdy_a), 32'd1);
    check("rst_rsp_valid_a", 32'(vld_a), 32'd0);
    check("rst_rsp_rdata_a", rdata_a, 32'd0);
    check("rst_rsp_err_a", 32'(err_a), 32'd0);
    check("rst_req_ready_b", 32'(rdy_b), 32'd1);
    check("rst_rsp_valid_b", 32'(vld_b), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 2-wait-state instance: directed cases, then random traffic.
    init_words();
    issue(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h1001_0004, 32'd0, 4'h0);
    issue(1'b1, 32'h1001_0004, 32'h0000_AA00, 4'b0010);
    issue(1'b0, 32'h1001_0004, 32'd0, 4'h0);
    issue(1'b0, 32'h1001_0006, 32'd0, 4'hF);
    issue(1'b0, 32'h0040_0000, 32'd0, 4'hF);
    issue(1'b1, 32'h1001_0006, 32'hFFFF_FFFF, 4'hF);
    issue(1'b0, 32'h1001_0004, 32'd0, 4'h0);
    issue(1'b1, 32'h1001_000C, 32'h5555_5555, 4'h0);
    issue(1'b0, 32'h1001_000C, 32'd0, 4'hF);
    drain();
    check("model_partial_store", ref_mem[0][1], 32'hDEAD_AAEF);

    // Backpressure: response held for five cycles with rsp_ready low.
    @(negedge clk);
    bp_mode = 1;
    issue(1'b0, 32'h1001_0004, 32'd0, 4'h0);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cur_vld) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_rsp_arrives", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(cur_vld), 32'd1);
    end
    bp_mode = 2;
    drain();
    @(negedge clk);
    bp_mode = 0;

    // Reset while a store is waiting: store is abandoned.
    issue(1'b1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF);
    drain();
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_addr  = 32'h1001_0008;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    check("rst_case_ready_before", 32'(cur_rdy), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_req_ready", 32'(rdy_a), 32'd1);
    check("async_rst_rsp_valid", 32'(vld_a), 32'd0);
    check("async_rst_rsp_err", 32'(err_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue(1'b0, 32'h1001_0008, 32'd0, 4'h0);
    drain();
    check("model_abandoned_store", ref_mem[0][2], 32'hCAFE_F00D);

    rand_phase(150);
    drain();

    // 0-wait-state instance: top-word boundary, then random traffic.
    @(negedge clk);
    sel = 1'b1;
    init_words();
    issue(1'b1, BASE + 32'(4 * DEPTH - 4), 32'hA5A5_0F0F, 4'hF);
    issue(1'b0, BASE + 32'(4 * DEPTH - 4), 32'd0, 4'h0);
    issue(1'b1, BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD, 4'hF);
    issue(1'b0, BASE + 32'(4 * DEPTH), 32'd0, 4'hF);
    issue(1'b0, BASE, 32'd0, 4'h0);
    issue(1'b0, BASE - 32'd4, 32'd0, 4'h0);
    rand_phase(150);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-organised data memory that answers load/store requests from the core datapath's data port (address, write data, read data).
- Accepts one request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two.
- BASE_ADDR, 32'h10010000, byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for store; bit i enables byte lane [8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; wait counter cleared.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not cleared; contents survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_write, req_addr, req_wdata, req_be; evaluate decode.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP directly when WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; on counter==0 move to RESP.
- Entering RESP (single edge):
  - Store with decode ok: write only enabled byte lanes; rsp_rdata=0.
  - Load with decode ok: rsp_rdata=full word, req_be ignored.
  - Decode fail: no memory update, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then the FSM returns to IDLE with rsp_valid=0.
  - No new request is accepted in the handshake cycle.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles.
- Decode:
  - ok iff req_addr[1:0]==0 and BASE_ADDR <= req_addr < BASE_ADDR+4*DEPTH_WORDS.
  - Word index = (req_addr-BASE_ADDR)>>2, width log2(DEPTH_WORDS).
  - Decode is computed from the latched address, never from live inputs.
- req_be=4'b0000 store: legal; no change to memory, rsp_err=0.
- Request inputs are don't-care while req_ready=0; changes to them must not affect the pending transaction.
- Reset mid-transaction: in WAIT, the pending store is abandoned and never committed. In RESP, the store was already committed and is kept; the response is dropped.
- Address arithmetic is 32-bit unsigned; the top-of-range word (BASE_ADDR+4*DEPTH_WORDS-4) is ok, and the next word is an error without wrapping to index 0.

Test Plan:
- WAIT_CYCLES=2: store 32'hDEADBEEF to 32'h10010004, be=4'hF, accepted at cycle 0 -> rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0. A load from 32'h10010004 then returns 32'hDEADBEEF at cycle 3 after its acceptance.
- Partial store 32'h0000AA00 with be=4'b0010 to 32'h10010004 -> subsequent load returns 32'hDEADAAEF.
- Load from 32'h10010006 (misaligned) and 32'h00400000 (out of range) -> rsp_err=1, rsp_rdata=0; a store to 32'h10010006 leaves 32'h10010004 reading 32'hDEADAAEF.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_rdata/rsp_err stable, req_ready=0. rsp_ready=1 -> rsp_valid=0 and req_ready=1 on the next cycle.
- Reset during WAIT: store 32'h12345678 to 32'h10010008 (previously 32'hCAFEF00D), pulse rst low one cycle after acceptance -> req_ready=1 and rsp_valid=0 immediately (asynchronous); a later load returns 32'hCAFEF00D.
- WAIT_CYCLES=0 and top-word boundary: store to BASE_ADDR+4*DEPTH_WORDS-4 -> rsp_valid one cycle after acceptance, ok. Access to BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1 and word 0 unchanged.
